// File: rtl/stats_accum_ram_if.sv
// Interface bundling the statistics increment stream, the host register
// read port and the clear/busy control pair of stats_accum_ram.
//   master : increment source / register reader (drives tdata, tid, tvalid,
//            rd_req, rd_addr, clear; observes tready, rd_valid, rd_data, busy)
//   slave  : the accumulator itself
interface stats_accum_ram_if #(
    parameter int STAT_INC_WIDTH = 24,
    parameter int STAT_ID_WIDTH  = 5
);
    logic [STAT_INC_WIDTH-1:0] s_axis_stat_tdata;
    logic [STAT_ID_WIDTH-1:0]  s_axis_stat_tid;
    logic                      s_axis_stat_tvalid;
    logic                      s_axis_stat_tready;
    logic                      rd_req;
    logic [STAT_ID_WIDTH:0]    rd_addr;
    logic                      rd_valid;
    logic [31:0]               rd_data;
    logic                      clear;
    logic                      busy;

    modport master (
        output s_axis_stat_tdata, s_axis_stat_tid, s_axis_stat_tvalid,
        input  s_axis_stat_tready,
        output rd_req, rd_addr,
        input  rd_valid, rd_data,
        output clear,
        input  busy
    );

    modport slave (
        input  s_axis_stat_tdata, s_axis_stat_tid, s_axis_stat_tvalid,
        output s_axis_stat_tready,
        input  rd_req, rd_addr,
        output rd_valid, rd_data,
        input  clear,
        output busy
    );
endinterface

// File: rtl/stats_accum_ram.sv
// Statistics accumulator: adds each accepted increment into a 64-bit counter
// held in block RAM (one per ID) and serves host reads as two 32-bit words,
// with a high-word shadow so a low-then-high read pair never tears.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : stats_accum_ram_if.slave -- increment stream (tdata/tid/tvalid/
//            tready), read port (rd_req/rd_addr -> rd_valid/rd_data two
//            cycles later), clear pulse and busy (zeroing sweep running)
module stats_accum_ram #(
    parameter int STAT_INC_WIDTH   = 24,
    parameter int STAT_ID_WIDTH    = 5,
    parameter int STAT_COUNT_WIDTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    stats_accum_ram_if.slave  bus
);
    localparam int N = 1 << STAT_ID_WIDTH;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                    state_reg, state_next;
    logic [STAT_ID_WIDTH-1:0]  sweep_reg, sweep_next;

    // increment pipeline: S2 registers hold the increment accepted last cycle
    logic                        s2_valid_reg;
    logic [STAT_ID_WIDTH-1:0]    s2_id_reg;
    logic [STAT_INC_WIDTH-1:0]   s2_inc_reg;
    // result of the previous S2 cycle, for back-to-back same-ID updates
    logic                        fwd_valid_reg;
    logic [STAT_ID_WIDTH-1:0]    fwd_id_reg;
    logic [STAT_COUNT_WIDTH-1:0] fwd_sum_reg;

    // read pipeline
    logic                        r1_valid_reg;
    logic                        r1_hi_reg;
    logic                        r1_zero_reg;
    logic                        r1_fwd_reg;
    logic [STAT_COUNT_WIDTH-1:0] r1_sum_reg;
    logic                        rd_valid_reg;
    logic [31:0]                 rd_data_reg;
    logic [31:0]                 shadow_reg;

    // counter RAM (no reset; the sweep defines its contents)
    logic [STAT_COUNT_WIDTH-1:0] ram [N];
    logic [STAT_COUNT_WIDTH-1:0] ram_q;

    logic                        in_run;
    logic                        accept;
    logic [STAT_ID_WIDTH-1:0]    rd_id;
    logic [STAT_ID_WIDTH-1:0]    ram_raddr;
    logic                        ram_we;
    logic [STAT_ID_WIDTH-1:0]    ram_waddr;
    logic [STAT_COUNT_WIDTH-1:0] ram_wdata;
    logic [STAT_COUNT_WIDTH-1:0] s2_base;
    logic [STAT_COUNT_WIDTH-1:0] s2_sum;
    logic [STAT_COUNT_WIDTH-1:0] rd_value;

    assign in_run = (state_reg == ST_RUN);
    assign rd_id  = bus.rd_addr[STAT_ID_WIDTH:1];

    // reads win over increments in the same cycle
    assign bus.s_axis_stat_tready = in_run & ~bus.rd_req;
    assign bus.busy               = ~in_run;
    assign accept                 = bus.s_axis_stat_tvalid & bus.s_axis_stat_tready;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_INIT;
            sweep_reg <= '0;
        end else begin
            state_reg <= state_next;
            sweep_reg <= sweep_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sweep_next = sweep_reg;
        if (bus.clear) begin
            state_next = ST_INIT;
            sweep_next = '0;
        end else if (state_reg == ST_INIT) begin
            sweep_next = sweep_reg + 1'b1;
            if (&sweep_reg) begin
                state_next = ST_RUN;
            end
        end
    end

    // ---------------- RAM ----------------
    // The RAM read returns pre-write data for a same-cycle write, so an update
    // accepted right after another to the same ID takes the previous sum from
    // fwd_sum_reg instead; updates two or more cycles apart see the RAM.
    assign s2_base = (fwd_valid_reg && (fwd_id_reg == s2_id_reg)) ? fwd_sum_reg : ram_q;
    assign s2_sum  = s2_base + STAT_COUNT_WIDTH'(s2_inc_reg);

    // S2 is always empty while sweeping, so the write port is never contended
    assign ram_we    = ~in_run | s2_valid_reg;
    assign ram_waddr = in_run ? s2_id_reg : sweep_reg;
    assign ram_wdata = in_run ? s2_sum : '0;
    assign ram_raddr = bus.rd_req ? rd_id : bus.s_axis_stat_tid;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
        ram_q <= ram[ram_raddr];
    end

    // ---------------- increment pipeline ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg  <= 1'b0;
            s2_id_reg     <= '0;
            s2_inc_reg    <= '0;
            fwd_valid_reg <= 1'b0;
            fwd_id_reg    <= '0;
            fwd_sum_reg   <= '0;
        end else begin
            // clear drops anything in flight; the sweep zeroes the rest
            s2_valid_reg  <= accept & ~bus.clear;
            fwd_valid_reg <= s2_valid_reg & ~bus.clear;
            fwd_id_reg    <= s2_id_reg;
            fwd_sum_reg   <= s2_sum;
            if (accept) begin
                s2_id_reg  <= bus.s_axis_stat_tid;
                s2_inc_reg <= bus.s_axis_stat_tdata;
            end
        end
    end

    // ---------------- read pipeline ----------------
    // Stage 1 (request cycle): the RAM read is issued; an update sitting in
    // S2 this cycle lands in RAM too late for that read, so its sum is
    // captured here. Stage 2 selects the value and formats the word.
    assign rd_value = r1_zero_reg ? '0 : (r1_fwd_reg ? r1_sum_reg : ram_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid_reg <= 1'b0;
            r1_hi_reg    <= 1'b0;
            r1_zero_reg  <= 1'b0;
            r1_fwd_reg   <= 1'b0;
            r1_sum_reg   <= '0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
            shadow_reg   <= '0;
        end else begin
            r1_valid_reg <= bus.rd_req;
            r1_hi_reg    <= bus.rd_addr[0];
            r1_zero_reg  <= ~in_run | bus.clear;
            r1_fwd_reg   <= s2_valid_reg & (s2_id_reg == rd_id);
            r1_sum_reg   <= s2_sum;
            rd_valid_reg <= r1_valid_reg;
            if (r1_valid_reg) begin
                if (r1_hi_reg) begin
                    rd_data_reg <= shadow_reg;
                end else begin
                    rd_data_reg <= rd_value[31:0];
                    shadow_reg  <= rd_value[63:32];
                end
            end
        end
    end

    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_data  = rd_data_reg;
endmodule
